// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial frame transmitter (start bit, N data bits LSB first, stop bit).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module serial_tx #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         send,
  input  logic [N-1:0] pdata,
  output logic         busy,
  output logic         sout
);

  localparam int DW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(N + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic [N-1:0]  shift;
  logic [N-1:0]  shift_d;
  logic          bit_done;
  logic          sout_nxt;
  logic          busy_nxt;
`ifdef SERIAL_TX_PARITY_EN
  logic          par;
`endif

  assign bit_done = (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (send) state_nxt = START;
      START:  if (bit_done) state_nxt = DATA;
`ifdef SERIAL_TX_PARITY_EN
      DATA:   if (bit_done && idx == IDX_LAST) state_nxt = PARITY;
      PARITY: if (bit_done) state_nxt = STOP;
`else
      DATA:   if (bit_done && idx == IDX_LAST) state_nxt = STOP;
`endif
      STOP:   if (bit_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so they can be registered without lag.
  always_comb begin
    shift_d = shift;
    if (state == IDLE && send)
      shift_d = pdata;
    else if (state == DATA && bit_done)
      shift_d = shift >> 1;

    busy_nxt = (state_nxt != IDLE);
    sout_nxt = 1'b1;
    case (state_nxt)
      START:  sout_nxt = 1'b0;
      DATA:   sout_nxt = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY: sout_nxt = par;
`endif
      default: sout_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div   <= '0;
      idx   <= '0;
      shift <= '0;
      busy  <= 1'b0;
      sout  <= 1'b1;
    end else begin
      shift <= shift_d;
      busy  <= busy_nxt;
      sout  <= sout_nxt;
      if (state == IDLE || bit_done) div <= '0;
      else                           div <= div + 1'b1;
      if (state == IDLE)                  idx <= '0;
      else if (state == DATA && bit_done) idx <= idx + 1'b1;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity is taken from the word at accept time because the shift register is consumed.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                 par <= 1'b0;
    else if (state == IDLE && send) par <= ^pdata;
  end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: scoreboard bench for serial_tx; a monitor decodes sout and compares against queued words.
// Follows SERIAL_TX_PARITY_EN so the expected frame matches the build under test.
module tb_serial_tx;

  localparam int N = 8;
  localparam int C = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FB  = N + 3;
  localparam int EFB = 4;
  localparam logic [3:0] EDGE_EXP = 4'b1110;
`else
  localparam int FB  = N + 2;
  localparam int EFB = 3;
  localparam logic [3:0] EDGE_EXP = 4'b0110;
`endif
  localparam int FL = FB * C;

  logic         clk = 1'b0;
  logic         rst_l = 1'b1;
  logic         send = 1'b0;
  logic [N-1:0] pdata = '0;
  logic         busy;
  logic         sout;
  logic         e_send = 1'b0;
  logic [0:0]   e_pdata = 1'b0;
  logic         e_busy;
  logic         e_sout;

  int errors = 0;
  int checks = 0;
  int sent = 0;
  int frames_rx = 0;
  bit abort_flag = 1'b0;
  logic [N-1:0] sb[$];

  serial_tx #(.N(N), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_l(rst_l), .send(send), .pdata(pdata), .busy(busy), .sout(sout)
  );

  serial_tx #(.N(1), .CLKS_PER_BIT(1)) dut_edge (
    .clk(clk), .rst_l(rst_l), .send(e_send), .pdata(e_pdata), .busy(e_busy), .sout(e_sout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FB-1:0] build_frame(input logic [N-1:0] w);
`ifdef SERIAL_TX_PARITY_EN
    return {1'b1, ^w, w, 1'b0};
`else
    return {1'b1, w, 1'b0};
`endif
  endfunction

  // Waits for idle, offers one word, and confirms the one-clock accept latency.
  task automatic applyStimulus(input logic [N-1:0] w, input bit extra_hold);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) checkOutput("pre_idle_timeout", 32'(busy), 32'(0));
    send = 1'b1;
    pdata = w;
    sb.push_back(w);
    sent++;
    @(posedge clk); #1;
    checkOutput("accept_busy", 32'(busy), 32'(1));
    checkOutput("accept_sout", 32'(sout), 32'(0));
    pdata = N'($urandom);
    if (extra_hold) begin
      @(posedge clk); #1;
    end
    send = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) checkOutput("idle_timeout", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [FB-1:0] got;
    logic          unstable;
    int            len;
    int            k;
    logic [N-1:0]  w;
    forever begin
      @(negedge clk);
      if (rst_l && busy) begin
        len = 0;
        got = '0;
        unstable = 1'b0;
        while (busy && len < FL + 8) begin
          if (len < FL) begin
            k = len / C;
            if (len % C == 0) got[k] = sout;
            else if (got[k] !== sout) unstable = 1'b1;
          end
          len++;
          @(negedge clk);
        end
        if (abort_flag) begin
          abort_flag = 1'b0;
          if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
          checkOutput("unexpected_frame", 32'(1), 32'(0));
        end else begin
          w = sb.pop_front();
          frames_rx++;
          checkOutput("frame", 32'(got), 32'(build_frame(w)));
          checkOutput("bit_stable", 32'(unstable), 32'(0));
          checkOutput("busy_len", 32'(len), 32'(FL));
          checkOutput("idle_sout", 32'(sout), 32'(1));
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [3:0] e_got;
    int         e_len;

    #2 rst_l = 1'b0;
    #1;
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_sout", 32'(sout), 32'(1));
    repeat (3) @(posedge clk);
    #3 rst_l = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_busy", 32'(busy), 32'(0));
    checkOutput("idle_sout_start", 32'(sout), 32'(1));

    applyStimulus(8'hA5, 1'b0);
    wait_idle();
    applyStimulus(8'h01, 1'b0);
    wait_idle();

    // send held high with churning pdata; the restart must land exactly at E0+FL+1
    send = 1'b1;
    pdata = 8'h3C;
    sb.push_back(8'h3C);
    sent++;
    @(posedge clk); #1;
    checkOutput("held_accept", 32'(busy), 32'(1));
    for (int t = 1; t <= FL + 1; t++) begin
      if (t == FL + 1) begin
        pdata = 8'h5A;
        sb.push_back(8'h5A);
        sent++;
      end else begin
        pdata = N'($urandom);
      end
      @(posedge clk); #1;
      if (t == FL) checkOutput("gap_busy", 32'(busy), 32'(0));
      if (t == FL + 1) checkOutput("restart_busy", 32'(busy), 32'(1));
    end
    send = 1'b0;
    wait_idle();

    // reset during data bit 3 of a frame
    abort_flag = 1'b1;
    applyStimulus(8'h96, 1'b0);
    repeat (17) @(posedge clk);
    #3 rst_l = 1'b0;
    #1;
    checkOutput("rst_mid_busy", 32'(busy), 32'(0));
    checkOutput("rst_mid_sout", 32'(sout), 32'(1));
    repeat (2) @(posedge clk);
    #3 rst_l = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post_rst_busy", 32'(busy), 32'(0));
    checkOutput("post_rst_sout", 32'(sout), 32'(1));
    checkOutput("post_rst_sb", 32'(sb.size()), 32'(0));
    applyStimulus(8'hFF, 1'b0);
    wait_idle();

    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      applyStimulus(N'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_idle();

    // N=1, one clock per bit
    e_send = 1'b1;
    e_pdata = 1'b1;
    @(posedge clk); #1;
    e_send = 1'b0;
    e_got = '0;
    e_len = 0;
    for (int i = 0; i < EFB; i++) begin
      e_got[i] = e_sout;
      if (e_busy) e_len++;
      @(posedge clk); #1;
    end
    checkOutput("edge_frame", 32'(e_got), 32'(EDGE_EXP));
    checkOutput("edge_busy_len", 32'(e_len), 32'(EFB));
    checkOutput("edge_end_busy", 32'(e_busy), 32'(0));
    checkOutput("edge_end_sout", 32'(e_sout), 32'(1));

    checkOutput("frame_count", 32'(frames_rx), 32'(sent - 1));
    checkOutput("sb_empty", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
